// File: rtl/act_interp_scheduler.sv
// Round-robin scheduler sharing one synchronous activation ROM and one combinational
// interpolator among N_REQ requesters; results return tagged with the requester id.
module act_interp_scheduler #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int IDX_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      lut_rd,
    output logic [IDX_W-1:0]          lut_addr,
    input  logic [DATA_W-1:0]         lut_rdata,
    output logic [DATA_W-1:0]         interp_base,
    output logic [DATA_W-1:0]         interp_next,
    output logic [DATA_W-1:0]         interp_rem,
    input  logic [DATA_W-1:0]         interp_value,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    input  logic                      resp_ready,
    output logic                      busy,
    output logic [2:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // the source holds data stable while valid is high and ready is low.
    typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, INTERP, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_q, grant_id, id_q, resp_id_q;
    logic                grant_found, hs;
    logic [DATA_W-1:0]   grant_data, base_q, resp_data_q;
    logic [DATA_W-1:0]   hold_base_q, hold_next_q, hold_rem_q, rem_ext;
    logic [FRAC_W-1:0]   rem_q;
    logic [IDX_W-1:0]    addr_q, nidx;

    // Integer part offset by half the table so the most negative value maps to entry 0.
    function automatic logic [IDX_W-1:0] to_idx(input logic [DATA_W-1:0] v);
        return {~v[DATA_W-1], v[DATA_W-2:FRAC_W]};
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_q) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    assign grant_data = req_data[grant_id*DATA_W +: DATA_W];
    assign hs         = (state_q == IDLE) && grant_found;
    assign nidx       = (addr_q == {IDX_W{1'b1}}) ? addr_q : addr_q + 1'b1;
    assign rem_ext    = {{(DATA_W-FRAC_W){1'b0}}, rem_q};

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        lut_rd     = 1'b0;
        resp_valid = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    req_ready = N_REQ'(1) << grant_id;
                    state_d   = RD_BASE;
                end
            end
            RD_BASE: begin
                lut_rd  = 1'b1;
                state_d = RD_NEXT;
            end
            RD_NEXT: begin
                lut_rd  = 1'b1;
                state_d = INTERP;
            end
            INTERP: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            hold_base_q <= '0;
            hold_next_q <= '0;
            hold_rem_q  <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        id_q   <= grant_id;
                        rem_q  <= grant_data[FRAC_W-1:0];
                        addr_q <= to_idx(grant_data);
                        rr_q   <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
                    end
                end
                RD_BASE: addr_q <= nidx;
                RD_NEXT: base_q <= lut_rdata;
                INTERP: begin
                    hold_base_q <= base_q;
                    hold_next_q <= lut_rdata;
                    hold_rem_q  <= rem_ext;
                    resp_data_q <= interp_value;
                    resp_id_q   <= id_q;
                end
                default: ;
            endcase
        end
    end

    // Interpolator inputs are live only in INTERP and keep their last value otherwise.
    assign interp_base = (state_q == INTERP) ? base_q    : hold_base_q;
    assign interp_next = (state_q == INTERP) ? lut_rdata : hold_next_q;
    assign interp_rem  = (state_q == INTERP) ? rem_ext   : hold_rem_q;
    assign lut_addr    = addr_q;
    assign resp_id     = resp_id_q;
    assign resp_data   = resp_data_q;
    assign dbg_state   = state_q;

endmodule
